mch_bit_dec: RTL and testbench

Manchester line front-end for the receive path. Synchronises the raw rxsd pin and recovers data bits by timing mid-bit transitions. Delivers a bit stream with framing strobes (sof/eof) and a line-error flag. Sits directly upstream of the frame/byte assembler that fills the received payload registers.

---
 rtl/mch_pkg.sv | 25 ++
 rtl/mch_sync_edge.sv | 79 +++++++
 rtl/mch_bit_dec.sv | 171 +++++++++++++++++
 tb/tb_mch_bit_dec.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mch_pkg.sv
// Manchester line-code package, shared by the receive decoder and the transmit encoder.
package mch_pkg;

    // Receive framing states
    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        ARMED     = 2'd1,
        FRAME     = 2'd2
    } mch_state_e;

    // A logic 1 is sent as a low-to-high mid-bit transition; the idle line sits high
    localparam logic MCH_ONE_RISE = 1'b1;
    localparam logic MCH_IDLE_LVL = 1'b1;

    // Earliest cycle count (3Q) at which an edge is treated as a mid-bit edge
    function automatic int mch_win_lo(input int bit_cyc);
        return 3 * (bit_cyc / 4);
    endfunction

    // Latest cycle count (5Q) at which an edge is still a mid-bit edge
    function automatic int mch_win_hi(input int bit_cyc);
        return 5 * (bit_cyc / 4);
    endfunction

endpackage

// File: rtl/mch_sync_edge.sv
// rxsd front end: 2-flop synchroniser, optional 3-sample glitch filter, rise/fall detect.
// Macro MCH_GLITCH_FILT_EN inserts the filter (edge latency grows by 2 cycles).
module mch_sync_edge
    import mch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rxsd,
    output logic s,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic prev_lvl;

    // Two-stage synchroniser for the asynchronous line, resting at the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= MCH_IDLE_LVL;
            s2_q <= MCH_IDLE_LVL;
        end else begin
            s1_q <= rxsd;
            s2_q <= s1_q;
        end
    end

`ifdef MCH_GLITCH_FILT_EN
    logic h1_q;
    logic h2_q;
    logic lvl_q;
    logic lvl_d;

    // Filtered level moves only once three consecutive samples agree
    always_comb begin
        lvl_d = lvl_q;
        if (s2_q && h1_q && h2_q) begin
            lvl_d = 1'b1;
        end else if (!s2_q && !h1_q && !h2_q) begin
            lvl_d = 1'b0;
        end
    end

    // Sample history and held filtered level (lvl_q doubles as the edge register)
    always_ff @(posedge clk) begin
        if (rst) begin
            h1_q  <= MCH_IDLE_LVL;
            h2_q  <= MCH_IDLE_LVL;
            lvl_q <= MCH_IDLE_LVL;
        end else begin
            h1_q  <= s2_q;
            h2_q  <= h1_q;
            lvl_q <= lvl_d;
        end
    end

    assign s        = lvl_d;
    assign prev_lvl = lvl_q;
`else
    logic prev_q;

    // Edge-detect register holding the previous synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= MCH_IDLE_LVL;
        end else begin
            prev_q <= s2_q;
        end
    end

    assign s        = s2_q;
    assign prev_lvl = prev_q;
`endif

    assign rise = s & ~prev_lvl;
    assign fall = ~s & prev_lvl;

endmodule

// File: rtl/mch_bit_dec.sv
// Manchester receive front end: recovers data bits from mid-bit transition timing and
// marks frame start/end. Optional macro MCH_GLITCH_FILT_EN enables the rxsd glitch filter.
module mch_bit_dec
    import mch_pkg::*;
#(
    parameter int BIT_CYC  = 1000,
    parameter int IDLE_CYC = 2000,
    parameter int CNT_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxsd,
    output logic       bit_o,
    output logic       bit_vld,
    output logic       sof,
    output logic       eof,
    output logic       err,
    output logic [7:0] bit_cnt,
    output logic       busy
);

    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam logic [CNT_W-1:0]  WIN_LO   = CNT_W'(mch_win_lo(BIT_CYC));
    localparam logic [CNT_W-1:0]  WIN_HI   = CNT_W'(mch_win_hi(BIT_CYC));
    localparam logic [IDLE_W-1:0] IDLE_TGT = IDLE_W'(IDLE_CYC);

    logic s;
    logic rise;
    logic fall;

    mch_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxsd (rxsd),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    mch_state_e        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [IDLE_W-1:0] idle_q,    idle_d;
    logic              bnd_q,     bnd_d;
    logic              bit_o_q,   bit_o_d;
    logic              bit_vld_q, bit_vld_d;
    logic              sof_q,     sof_d;
    logic              eof_q,     eof_d;
    logic              err_q,     err_d;
    logic [7:0]        bit_cnt_q, bit_cnt_d;

    // elapsed counts the current cycle too, so an edge N cycles after the last
    // mid-bit edge is judged against N
    logic [CNT_W-1:0]  elapsed;
    logic [IDLE_W-1:0] idle_nx;

    // Next-state and strobe logic for idle qualification, start detect and bit timing
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        bnd_d     = bnd_q;
        bit_o_d   = bit_o_q;
        bit_cnt_d = bit_cnt_q;
        bit_vld_d = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        err_d     = 1'b0;
        elapsed   = cnt_q + CNT_W'(1);
        idle_nx   = idle_q + IDLE_W'(1);

        case (state_q)
            IDLE_WAIT: begin
                if (s == MCH_IDLE_LVL) begin
                    if (idle_nx >= IDLE_TGT) begin
                        state_d = ARMED;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_nx;
                    end
                end else begin
                    idle_d = '0;
                end
            end

            ARMED: begin
                // Falling edge here is the mid-bit transition of the start bit
                if (fall) begin
                    sof_d     = 1'b1;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    bnd_d     = 1'b0;
                    state_d   = FRAME;
                end
            end

            FRAME: begin
                if ((rise || fall) && (elapsed <= WIN_HI)) begin
                    if (elapsed < WIN_LO) begin
                        // Early edge: one boundary edge per bit is legal, a second is a violation
                        if (bnd_q) begin
                            eof_d   = 1'b1;
                            err_d   = 1'b1;
                            state_d = IDLE_WAIT;
                            idle_d  = '0;
                        end else begin
                            bnd_d = 1'b1;
                            cnt_d = elapsed;
                        end
                    end else begin
                        bit_vld_d = 1'b1;
                        bit_o_d   = rise ? MCH_ONE_RISE : ~MCH_ONE_RISE;
                        if (bit_cnt_q != 8'hFF) begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                        cnt_d = '0;
                        bnd_d = 1'b0;
                    end
                end else if (elapsed > WIN_HI) begin
                    // No mid-bit edge in the window: frame over, clean only if line is back at idle
                    eof_d   = 1'b1;
                    err_d   = (s != MCH_IDLE_LVL);
                    state_d = IDLE_WAIT;
                    idle_d  = '0;
                end else begin
                    cnt_d = elapsed;
                end
            end

            default: begin
                state_d = IDLE_WAIT;
                idle_d  = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE_WAIT;
            cnt_q     <= '0;
            idle_q    <= '0;
            bnd_q     <= 1'b0;
            bit_o_q   <= 1'b0;
            bit_vld_q <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            bnd_q     <= bnd_d;
            bit_o_q   <= bit_o_d;
            bit_vld_q <= bit_vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_o   = bit_o_q;
    assign bit_vld = bit_vld_q;
    assign sof     = sof_q;
    assign eof     = eof_q;
    assign err     = err_q;
    assign bit_cnt = bit_cnt_q;
    assign busy    = (state_q == FRAME);

endmodule

// File: tb/tb_mch_bit_dec.sv
// Directed bench for mch_bit_dec with BIT_CYC = 16, IDLE_CYC = 32 (Q = 4, window 12..20).
module tb_mch_bit_dec;

    localparam int BIT_CYC  = 16;
    localparam int IDLE_CYC = 32;
    localparam int CNT_W    = 12;
    localparam int H        = BIT_CYC / 2;
`ifdef MCH_GLITCH_FILT_EN
    localparam int LAT      = 5;
    localparam int GLITCH_N = 0;
`else
    localparam int LAT      = 3;
    localparam int GLITCH_N = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rxsd;
    logic       bit_o;
    logic       bit_vld;
    logic       sof;
    logic       eof;
    logic       err;
    logic [7:0] bit_cnt;
    logic       busy;

    mch_bit_dec #(.BIT_CYC(BIT_CYC), .IDLE_CYC(IDLE_CYC), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxsd    (rxsd),
        .bit_o   (bit_o),
        .bit_vld (bit_vld),
        .sof     (sof),
        .eof     (eof),
        .err     (err),
        .bit_cnt (bit_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int          n_sof = 0, n_bit = 0, n_eof = 0, n_err = 0, n_excl = 0;
    int          last_sof_cyc = 0, last_bit_cyc = 0, last_eof_cyc = 0, first_bit_cyc = 0;
    logic [31:0] bits_log = '0;
    bit          pend_first = 1'b0;

    always @(negedge clk) begin
        if (sof) begin
            n_sof++;
            last_sof_cyc = cyc;
            pend_first   = 1'b1;
        end
        if (bit_vld) begin
            n_bit++;
            bits_log     = {bits_log[30:0], bit_o};
            last_bit_cyc = cyc;
            if (pend_first) begin
                first_bit_cyc = cyc;
                pend_first    = 1'b0;
            end
        end
        if (eof) begin
            n_eof++;
            last_eof_cyc = cyc;
        end
        if (err) n_err++;
        if ((int'(sof) + int'(bit_vld) + int'(eof)) > 1 || (err && !eof)) n_excl++;
    end

    int checks = 0;
    int errors = 0;
    int b_sof, b_bit, b_eof, b_err;
    int mid_drv = 0;

    task automatic snap();
        b_sof = n_sof;
        b_bit = n_bit;
        b_eof = n_eof;
        b_err = n_err;
    endtask

    // Drive a level for n cycles; inputs change 1 time unit after the rising edge
    task automatic hold(input logic lvl, input int n);
        rxsd = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_start();
        hold(1'b1, H);
        hold(1'b0, H);
    endtask

    task automatic send_bit(input logic b);
        hold(~b, H);
        mid_drv = cyc;
        hold(b, H);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        rxsd = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++; if ({bit_o, bit_vld, sof, eof, err, busy} !== 6'b0) begin errors++; $display("FAIL rst_outs got %b exp 000000", {bit_o, bit_vld, sof, eof, err, busy}); end
        checks++; if (bit_cnt !== 8'd0) begin errors++; $display("FAIL rst_bit_cnt got %0d exp 0", bit_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_frame_a5();
        logic [7:0] v;
        int first_mid;
        v = 8'hA5;
        first_mid = 0;
        hold(1'b1, 40);
        snap();
        send_start();
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (i == 7) first_mid = mid_drv;
        end
        hold(1'b1, 30);
        checks++; if (n_sof - b_sof !== 1) begin errors++; $display("FAIL a5_sof got %0d exp 1", n_sof - b_sof); end
        checks++; if (n_bit - b_bit !== 8) begin errors++; $display("FAIL a5_nbits got %0d exp 8", n_bit - b_bit); end
        checks++; if (bits_log[7:0] !== 8'hA5) begin errors++; $display("FAIL a5_data got %h exp a5", bits_log[7:0]); end
        checks++; if (n_eof - b_eof !== 1) begin errors++; $display("FAIL a5_eof got %0d exp 1", n_eof - b_eof); end
        checks++; if (n_err - b_err !== 0) begin errors++; $display("FAIL a5_err got %0d exp 0", n_err - b_err); end
        checks++; if (bit_cnt !== 8'd8) begin errors++; $display("FAIL a5_bit_cnt got %0d exp 8", bit_cnt); end
        checks++; if (first_bit_cyc - first_mid !== LAT) begin errors++; $display("FAIL a5_latency got %0d exp %0d", first_bit_cyc - first_mid, LAT); end
        checks++; if (last_eof_cyc - last_bit_cyc !== 21) begin errors++; $display("FAIL a5_eof_delay got %0d exp 21", last_eof_cyc - last_bit_cyc); end
        checks++; if (bit_o !== 1'b1) begin errors++; $display("FAIL a5_bit_o_hold got %b exp 1", bit_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy got %b exp 0", busy); end
    endtask

    task automatic test_err_low();
        hold(1'b1, 40);
        snap();
        send_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        hold(1'b0, 30);
        checks++; if (n_bit - b_bit !== 3) begin errors++; $display("FAIL low_nbits got %0d exp 3", n_bit - b_bit); end
        checks++; if (bits_log[2:0] !== 3'b110) begin errors++; $display("FAIL low_data got %b exp 110", bits_log[2:0]); end
        checks++; if (n_eof - b_eof !== 1) begin errors++; $display("FAIL low_eof got %0d exp 1", n_eof - b_eof); end
        checks++; if (n_err - b_err !== 1) begin errors++; $display("FAIL low_err got %0d exp 1", n_err - b_err); end
        checks++; if (bit_cnt !== 8'd3) begin errors++; $display("FAIL low_bit_cnt got %0d exp 3", bit_cnt); end
        checks++; if (bit_o !== 1'b0) begin errors++; $display("FAIL low_bit_o got %b exp 0", bit_o); end
    endtask

    task automatic test_violation();
        hold(1'b1, 40);
        snap();
        hold(1'b1, H);
        hold(1'b0, 4);
        hold(1'b1, 3);
        hold(1'b0, 10);
        checks++; if (n_sof - b_sof !== 1) begin errors++; $display("FAIL viol_sof got %0d exp 1", n_sof - b_sof); end
        checks++; if (n_bit - b_bit !== 0) begin errors++; $display("FAIL viol_nbits got %0d exp 0", n_bit - b_bit); end
        checks++; if (n_eof - b_eof !== 1) begin errors++; $display("FAIL viol_eof got %0d exp 1", n_eof - b_eof); end
        checks++; if (n_err - b_err !== 1) begin errors++; $display("FAIL viol_err got %0d exp 1", n_err - b_err); end
        checks++; if (last_eof_cyc - last_sof_cyc !== 7) begin errors++; $display("FAIL viol_timing got %0d exp 7", last_eof_cyc - last_sof_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL viol_busy got %b exp 0", busy); end
    endtask

    task automatic test_idle_and_windows();
        snap();
        hold(1'b1, 20);
        hold(1'b0, 8);
        checks++; if (n_sof - b_sof !== 0) begin errors++; $display("FAIL short_idle_sof got %0d exp 0", n_sof - b_sof); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_idle_busy got %b exp 0", busy); end
        hold(1'b1, 40);
        snap();
        hold(1'b0, 12);
        hold(1'b1, 20);
        hold(1'b0, 21);
        hold(1'b1, 30);
        checks++; if (n_sof - b_sof !== 1) begin errors++; $display("FAIL win_sof got %0d exp 1", n_sof - b_sof); end
        checks++; if (n_bit - b_bit !== 2) begin errors++; $display("FAIL win_nbits got %0d exp 2", n_bit - b_bit); end
        checks++; if (bits_log[1:0] !== 2'b10) begin errors++; $display("FAIL win_data got %b exp 10", bits_log[1:0]); end
        checks++; if (n_eof - b_eof !== 1) begin errors++; $display("FAIL win_eof got %0d exp 1", n_eof - b_eof); end
        checks++; if (n_err - b_err !== 0) begin errors++; $display("FAIL win_err got %0d exp 0", n_err - b_err); end
        checks++; if (last_eof_cyc - last_bit_cyc !== 21) begin errors++; $display("FAIL win_gap21 got %0d exp 21", last_eof_cyc - last_bit_cyc); end
        checks++; if (bit_cnt !== 8'd2) begin errors++; $display("FAIL win_bit_cnt got %0d exp 2", bit_cnt); end
    endtask

    task automatic test_glitch();
        hold(1'b1, 40);
        snap();
        hold(1'b0, 1);
        hold(1'b1, 30);
        checks++; if (n_sof - b_sof !== GLITCH_N) begin errors++; $display("FAIL glitch_sof got %0d exp %0d", n_sof - b_sof, GLITCH_N); end
        checks++; if (n_eof - b_eof !== GLITCH_N) begin errors++; $display("FAIL glitch_eof got %0d exp %0d", n_eof - b_eof, GLITCH_N); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
    endtask

    task automatic test_saturate();
        hold(1'b1, 40);
        snap();
        send_start();
        repeat (258) send_bit(1'b1);
        hold(1'b1, 30);
        checks++; if (n_bit - b_bit !== 258) begin errors++; $display("FAIL sat_nbits got %0d exp 258", n_bit - b_bit); end
        checks++; if (bit_cnt !== 8'd255) begin errors++; $display("FAIL sat_bit_cnt got %0d exp 255", bit_cnt); end
        checks++; if (n_eof - b_eof !== 1 || n_err - b_err !== 0) begin errors++; $display("FAIL sat_eof got eof %0d err %0d exp 1 0", n_eof - b_eof, n_err - b_err); end
    endtask

    task automatic test_reset_mid_frame();
        hold(1'b1, 40);
        snap();
        send_start();
        send_bit(1'b1);
        checks++; if (busy !== 1'b1 || bit_cnt !== 8'd1) begin errors++; $display("FAIL midrst_pre got busy %b cnt %0d exp 1 1", busy, bit_cnt); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if ({bit_o, bit_vld, sof, eof, err, busy} !== 6'b0) begin errors++; $display("FAIL midrst_outs got %b exp 000000", {bit_o, bit_vld, sof, eof, err, busy}); end
        checks++; if (bit_cnt !== 8'd0) begin errors++; $display("FAIL midrst_bit_cnt got %0d exp 0", bit_cnt); end
        hold(1'b1, 40);
        checks++; if (n_eof - b_eof !== 0) begin errors++; $display("FAIL midrst_eof got %0d exp 0", n_eof - b_eof); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_err_low();
        test_violation();
        test_idle_and_windows();
        test_glitch();
        test_saturate();
        test_reset_mid_frame();
        checks++; if (n_excl !== 0) begin errors++; $display("FAIL exclusive_strobes got %0d exp 0", n_excl); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
